// File: rtl/dsch_clk_div_gen.sv
// dsch_clk_div_gen: resettable divided-clock generator with edge strobes, rising-edge counter and sticky done.
// Optional feature macro: DSCH_CLK_DIV_GEN_CLK2_EN adds a clk_div/2 output and folds its falling edge into or_stb.
module dsch_clk_div_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div_half,
  input  logic [CNT_W-1:0] stop_cyc,
  output logic             clk_div,
  output logic             clk_inv,
  output logic             pos_stb,
  output logic             neg_stb,
  output logic             clk_div2,
  output logic             or_stb,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [DIV_W-1:0] hp_cnt, hp_cnt_n, ratio_q, ratio_n, ratio_in;
  logic [CNT_W-1:0] cyc_cnt_n, cnt_inc;
  logic             step, tog, rise, term, clk_div_n;
  // Next state, divider progress and counter; ratio_q also tracks div_half while idle between half-periods
  always_comb begin
    ratio_in  = div_half == '0 ? DIV_W'(1) : div_half;
    cnt_inc   = cyc_cnt + CNT_W'(1);
    step      = state == RUN && en;
    tog       = step && hp_cnt == ratio_q - DIV_W'(1);
    rise      = tog && !clk_div;
    term      = rise && stop_cyc != '0 && cnt_inc == stop_cyc && !clr;
    clk_div_n = clk_div ^ tog;
    hp_cnt_n  = tog ? '0 : step ? hp_cnt + DIV_W'(1) : hp_cnt;
    ratio_n   = (tog || (state == IDLE && hp_cnt == '0)) ? ratio_in : ratio_q;
    cyc_cnt_n = clr ? '0 : rise ? cnt_inc : cyc_cnt;
    state_n   = state == IDLE ? (en ? RUN : IDLE) :
                state == RUN  ? (!en ? IDLE : term ? DONE : RUN) :
                (clr ? IDLE : DONE);
  end
  // State and registered outputs; strobes land in the same cycle as the new clk_div level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      hp_cnt  <= '0;
      ratio_q <= DIV_W'(1);
      clk_div <= 1'b0;
      clk_inv <= 1'b1;
      pos_stb <= 1'b0;
      neg_stb <= 1'b0;
      cyc_cnt <= '0;
    end else begin
      state   <= state_n;
      hp_cnt  <= hp_cnt_n;
      ratio_q <= ratio_n;
      clk_div <= clk_div_n;
      clk_inv <= ~clk_div_n;
      pos_stb <= rise;
      neg_stb <= tog && clk_div;
      cyc_cnt <= cyc_cnt_n;
    end
  end
  assign done = state == DONE;
`ifdef DSCH_CLK_DIV_GEN_CLK2_EN
  logic neg2_stb;
  // Half-rate clock flips on each clk_div rising toggle; its fall always coincides with a pos_stb
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_div2 <= 1'b0;
      neg2_stb <= 1'b0;
    end else begin
      clk_div2 <= clk_div2 ^ rise;
      neg2_stb <= rise && clk_div2;
    end
  end
  assign or_stb = pos_stb | neg2_stb;
`else
  assign clk_div2 = 1'b0;
  assign or_stb   = pos_stb;
`endif
endmodule

// File: tb/tb_dsch_clk_div_gen.sv
// tb_dsch_clk_div_gen: table-driven and directed checks of the divided-clock generator.
module tb_dsch_clk_div_gen;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0;
  logic [7:0]  div_half = 8'd1;
  logic [31:0] stop_cyc = '0;
  logic        clk_div, clk_inv, pos_stb, neg_stb, clk_div2, or_stb, done;
  logic [31:0] cyc_cnt;
  int checks = 0, failures = 0;
  typedef struct {
    logic        en, clr;
    logic [7:0]  dh;
    logic [31:0] sc;
    logic        e_div, e_pos, e_neg;
    logic [31:0] e_cnt;
    logic        e_done;
  } vec_t;
  vec_t tv[16];
  dsch_clk_div_gen dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .div_half(div_half), .stop_cyc(stop_cyc),
    .clk_div(clk_div), .clk_inv(clk_inv), .pos_stb(pos_stb), .neg_stb(neg_stb),
    .clk_div2(clk_div2), .or_stb(or_stb), .cyc_cnt(cyc_cnt), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic e, input logic c, input logic [7:0] dh, input logic [31:0] sc,
                              input logic d, input logic p, input logic n, input logic [31:0] cnt, input logic dn);
    vec_t v;
    v.en = e; v.clr = c; v.dh = dh; v.sc = sc;
    v.e_div = d; v.e_pos = p; v.e_neg = n; v.e_cnt = cnt; v.e_done = dn;
    return v;
  endfunction
  task automatic do_reset(input logic [7:0] dh, input logic [31:0] sc);
    rst = 1'b1; en = 1'b0; clr = 1'b0; div_half = dh; stop_cyc = sc;
    @(negedge clk);
    @(negedge clk);
    en = 1'b1; rst = 1'b0;
  endtask
  initial begin
    int pe[$];
    int ep[4];
    bit seen;
    ep = '{2, 6, 12, 20};
    tv[0]  = mk(1, 0, 1, 5, 0, 0, 0, 0, 0);
    tv[1]  = mk(1, 0, 1, 5, 1, 1, 0, 1, 0);
    tv[2]  = mk(1, 0, 1, 5, 0, 0, 1, 1, 0);
    tv[3]  = mk(1, 0, 1, 5, 1, 1, 0, 2, 0);
    tv[4]  = mk(1, 0, 1, 5, 0, 0, 1, 2, 0);
    tv[5]  = mk(1, 0, 1, 5, 1, 1, 0, 3, 0);
    tv[6]  = mk(1, 0, 1, 5, 0, 0, 1, 3, 0);
    tv[7]  = mk(1, 0, 1, 5, 1, 1, 0, 4, 0);
    tv[8]  = mk(1, 0, 1, 5, 0, 0, 1, 4, 0);
    tv[9]  = mk(1, 0, 1, 5, 1, 1, 0, 5, 1);
    tv[10] = mk(1, 0, 1, 5, 1, 0, 0, 5, 1);
    tv[11] = mk(1, 0, 1, 5, 1, 0, 0, 5, 1);
    tv[12] = mk(1, 1, 1, 5, 1, 0, 0, 0, 0);
    tv[13] = mk(1, 0, 1, 5, 1, 0, 0, 0, 0);
    tv[14] = mk(1, 0, 1, 5, 0, 0, 1, 0, 0);
    tv[15] = mk(1, 0, 1, 5, 1, 1, 0, 1, 0);
    rst = 1'b1; en = 1'b1; div_half = 8'd1; stop_cyc = 32'd5;
    @(negedge clk);
    chk("reset_flags", {clk_div, clk_inv, pos_stb, neg_stb, done, or_stb, clk_div2}, 7'b0100000);
    chk("reset_cnt", cyc_cnt, 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      en = tv[i].en; clr = tv[i].clr; div_half = tv[i].dh; stop_cyc = tv[i].sc;
      @(negedge clk);
      chk($sformatf("vec%0d_flags", i), {clk_div, clk_inv, pos_stb, neg_stb, done, or_stb},
          {tv[i].e_div, ~tv[i].e_div, tv[i].e_pos, tv[i].e_neg, tv[i].e_done, tv[i].e_pos});
      chk($sformatf("vec%0d_cnt", i), cyc_cnt, tv[i].e_cnt);
    end
    clr = 1'b0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    chk("recount_done", done, 1);
    chk("recount_cnt", cyc_cnt, 5);
    chk("recount_frozen", clk_div, 1);
    do_reset(8'd3, 32'd0);
    for (int k = 0; k < 100; k++) begin
      logic ed, ep_, en_;
      @(negedge clk);
      ed  = ((k / 3) % 2) == 1;
      ep_ = k > 0 && k % 3 == 0 && ed;
      en_ = k > 0 && k % 3 == 0 && !ed;
      chk($sformatf("div3_e%0d", k), {clk_div, clk_inv, pos_stb, neg_stb, done}, {ed, ~ed, ep_, en_, 1'b0});
    end
    chk("div3_cnt", cyc_cnt, 17);
    do_reset(8'd2, 32'd0);
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      if (pos_stb) pe.push_back(k);
      if (k == 7) div_half = 8'd4;
    end
    chk("chg_pos_count", pe.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("chg_pos%0d", i), i < pe.size() ? pe[i] : -1, ep[i]);
    do_reset(8'd4, 32'd0);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k >= 6 && k <= 12) begin
        chk($sformatf("pause_e%0d", k), {clk_div, pos_stb, neg_stb}, 3'b100);
        chk($sformatf("pause_cnt%0d", k), cyc_cnt, 1);
      end
      if (k == 15) chk("resume_early", {clk_div, neg_stb}, 2'b10);
      if (k == 16) chk("resume_neg", {clk_div, neg_stb}, 2'b01);
      if (k == 20) chk("resume_pos", {clk_div, pos_stb, cyc_cnt}, {1'b1, 1'b1, 32'd2});
      if (k == 5) en = 1'b0;
      if (k == 12) en = 1'b1;
    end
    rst = 1'b1;
    #1;
    chk("async_rst_flags", {clk_div, clk_inv, pos_stb, neg_stb, done, or_stb, clk_div2}, 7'b0100000);
    chk("async_rst_cnt", cyc_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_e0", {clk_div, pos_stb, neg_stb}, 3'b000);
    do_reset(8'd0, 32'd0);
    @(negedge clk);
    chk("dh0_e0", {clk_div, pos_stb}, 2'b00);
    @(negedge clk);
    chk("dh0_e1", {clk_div, pos_stb}, 2'b11);
    do_reset(8'd1, 32'd2);
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      clr = k == 2;
      if (k == 1) chk("clrterm_e1", cyc_cnt, 1);
      if (k == 3) chk("clrterm_e3", {clk_div, pos_stb, done, cyc_cnt}, {1'b1, 1'b1, 1'b0, 32'd0});
      if (k == 6) chk("clrterm_e6", {done, cyc_cnt}, {1'b0, 32'd1});
      if (k == 7) chk("clrterm_e7", {done, cyc_cnt}, {1'b1, 32'd2});
    end
    do_reset(8'd1, 32'd0);
    for (int k = 0; k < 12; k++) begin
      logic e2;
      @(negedge clk);
`ifdef DSCH_CLK_DIV_GEN_CLK2_EN
      e2 = (((k + 1) / 2) % 2) == 1;
`else
      e2 = 1'b0;
`endif
      chk($sformatf("div2_e%0d", k), {clk_div2, or_stb}, {e2, k % 2 == 1});
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
